pattern_gen: RTL
================

PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, meaning lines per frame.
REQ-003 SHALL have port clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port trigger  input  1  start-of-frame request from the VGA generator, one-cycle pulse.
REQ-006 SHALL have port rect_x  input  11  rectangle left column.
REQ-007 SHALL have port rect_y  input  10  rectangle top row.
REQ-008 SHALL have port rect_w  input  11  rectangle width in pixels.
REQ-009 SHALL have port rect_h  input  10  rectangle height in lines.
REQ-010 SHALL have port fg  input  16  RGB565 rectangle colour.
REQ-011 SHALL have port bg  input  16  RGB565 background colour.
REQ-012 SHALL have port fifo_full  input  1  pixel FIFO cannot accept data this cycle.
REQ-013 SHALL have port fifo_write  output  1  fifo_data valid and written this cycle.
REQ-014 SHALL have port fifo_data  output  16  RGB565 pixel, bits [15:11] red, [10:5] green, [4:0] blue.
REQ-015 SHALL have port busy  output  1  frame generation in progress.
REQ-016 SHALL have port overrun  output  1  sticky flag: trigger arrived while busy.

Function
REQ-017 SHALL implement FSM states IDLE and RUN; reset enters IDLE.
REQ-018 In IDLE with trigger=1, SHALL latch rect_x/y/w/h, fg, and bg into shadow registers, clear x=0 and y=0, and enter RUN on the next edge.
REQ-019 SHALL treat parameter inputs as don't-care outside the latch cycle; each frame uses only the latched values.
REQ-020 SHALL drive fifo_write = (state==RUN) & ~fifo_full combinationally; it SHALL never assert while fifo_full=1.
REQ-021 SHALL drive fifo_data combinationally from the registered x, y, and shadow registers; no added latency.
REQ-022 On each write, x SHALL increment; at x==H_ACTIVE-1, x SHALL wrap to 0 and y SHALL increment.
REQ-023 On the write with x==H_ACTIVE-1 and y==V_ACTIVE-1, SHALL return to IDLE; exactly H_ACTIVE*V_ACTIVE writes SHALL occur per frame.
REQ-024 When fifo_full=1 in RUN, x, y, and the state SHALL hold.
REQ-025 A pixel is inside the rectangle when x>=rect_x, x<rect_x+rect_w, y>=rect_y, and y<rect_y+rect_h; sums SHALL be computed at 12 bits, with no wrap.
REQ-026 Inside pixels SHALL be fg; all other pixels SHALL be bg.
REQ-027 rect_w=0 or rect_h=0 SHALL draw no rectangle; a rectangle extending past the screen edge SHALL be clipped.
REQ-028 A trigger in RUN SHALL restart the frame: re-latch parameters, x=y=0, stay in RUN, and set overrun=1.
REQ-029 A trigger coinciding with the final write SHALL start a new frame with no idle cycle; overrun SHALL NOT be set.
REQ-030 busy SHALL be 1 exactly when state==RUN.

Reset
REQ-031 reset_n=0 SHALL immediately force state=IDLE, x=0, y=0, overrun=0, busy=0, fifo_write=0, and shadow registers=0.
REQ-032 Reset mid-frame SHALL abandon the frame; no write SHALL occur until the next trigger after reset_n=1.
REQ-033 overrun SHALL be cleared only by reset.

Configuration
REQ-034 With PATTERN_BORDER_EN defined, pixels with x==0, x==H_ACTIVE-1, y==0, or y==V_ACTIVE-1 SHALL be 16'hFFFF, overriding both fg and bg.
REQ-035 Without PATTERN_BORDER_EN, no border SHALL be drawn and no border logic SHALL be present.

Structure
REQ-036 Package vga_pkg SHALL hold the rgb565_t typedef, the H_ACTIVE/V_ACTIVE defaults, the colour constants (WHITE=16'hFFFF, BLACK=16'h0000), and the FSM state enum.
REQ-037 One sub-module, rect_hit, SHALL perform the combinational inside test (x, y, shadow geometry -> hit).

Verification
REQ-038 Reset, trigger, fifo_full=0, rect=(0,0,0,0), bg=16'h001F -> 307200 writes, all 16'h001F, busy falls after the last write.
REQ-039 rect=(10,20,5,3), fg=16'hF800, bg=0 -> exactly 15 pixels F800, at x 10..14 and y 20..22.
REQ-040 fifo_full toggled randomly at 50% -> no write while full, pixel order unchanged, total 307200.
REQ-041 Second trigger at pixel 1000 -> overrun=1, next write is pixel (0,0), and frame count restarts.
REQ-042 rect=(635,478,20,20) -> hits only at x 635..639 and y 478..479; with PATTERN_BORDER_EN, the edge pixels are FFFF.
REQ-043 reset_n pulsed low mid-frame -> fifo_write=0 at once; no writes until a new trigger.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the rectangle test-pattern generator.
// The optional frame border is enabled by defining PATTERN_BORDER_EN.
package vga_pkg;

    typedef logic [15:0] rgb565_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    localparam rgb565_t WHITE = 16'hFFFF;
    localparam rgb565_t BLACK = 16'h0000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic [10:0] w;
        logic [9:0]  h;
    } rect_t;

endpackage

// File: rtl/rect_hit.sv
// Combinational inside-rectangle test for the current pixel position.
// End coordinates are formed at 12 bits so a rectangle running off screen never wraps.
module rect_hit
    import vga_pkg::*;
(
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  rect_t       rect,
    output logic        hit
);

    logic [11:0] x_end;
    logic [11:0] y_end;
    logic        in_x;
    logic        in_y;

    assign x_end = {1'b0, rect.x} + {1'b0, rect.w};
    assign y_end = {2'b00, rect.y} + {2'b00, rect.h};

    // Zero width or height makes the half-open interval empty.
    assign in_x = (x >= rect.x) && ({1'b0, x} < x_end);
    assign in_y = (y >= rect.y) && ({2'b00, y} < y_end);

    assign hit = in_x && in_y;

endmodule

// File: rtl/pattern_gen.sv
// Streams one RGB565 frame per trigger into a pixel FIFO: a filled rectangle on a background.
// Defining PATTERN_BORDER_EN paints the outermost rows/columns white.
//
// Handshake: a pixel transfers on every cycle where fifo_write=1; fifo_write is
// (state==RUN & ~fifo_full), so the FIFO's full flag is the only back-pressure.
module pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        trigger,
    input  logic [10:0] rect_x,
    input  logic [9:0]  rect_y,
    input  logic [10:0] rect_w,
    input  logic [9:0]  rect_h,
    input  logic [15:0] fg,
    input  logic [15:0] bg,
    input  logic        fifo_full,
    output logic        fifo_write,
    output logic [15:0] fifo_data,
    output logic        busy,
    output logic        overrun
);

    localparam logic [10:0] X_LAST = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  Y_LAST = 10'(V_ACTIVE - 1);

    state_t      state;
    logic [10:0] x;
    logic [9:0]  y;
    rect_t       sh_rect;
    rgb565_t     sh_fg;
    rgb565_t     sh_bg;
    logic        hit;
    logic        last_px;
    logic        frame_done;

    assign fifo_write = (state == RUN) && !fifo_full;
    assign busy       = (state == RUN);
    assign last_px    = (x == X_LAST) && (y == Y_LAST);
    assign frame_done = fifo_write && last_px;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            overrun <= 1'b0;
            sh_rect <= '0;
            sh_fg   <= BLACK;
            sh_bg   <= BLACK;
        end else if (trigger) begin
            // A trigger always (re)starts a frame; only one that cuts a frame short is an overrun.
            sh_rect <= '{x: rect_x, y: rect_y, w: rect_w, h: rect_h};
            sh_fg   <= fg;
            sh_bg   <= bg;
            x       <= '0;
            y       <= '0;
            state   <= RUN;
            if (state == RUN && !frame_done) begin
                overrun <= 1'b1;
            end
        end else if (fifo_write) begin
            if (x == X_LAST) begin
                x <= '0;
                if (y == Y_LAST) begin
                    y     <= '0;
                    state <= IDLE;
                end else begin
                    y <= y + 10'd1;
                end
            end else begin
                x <= x + 11'd1;
            end
        end
    end

    rect_hit u_rect_hit (
        .x    (x),
        .y    (y),
        .rect (sh_rect),
        .hit  (hit)
    );

`ifdef PATTERN_BORDER_EN
    logic on_border;
    assign on_border = (x == '0) || (x == X_LAST) || (y == '0) || (y == Y_LAST);
    assign fifo_data = on_border ? WHITE : (hit ? sh_fg : sh_bg);
`else
    assign fifo_data = hit ? sh_fg : sh_bg;
`endif

endmodule
